// File: rtl/dilation_seq_pkg.sv
// Shared types and helpers for the dilated-convolution layer sequencer.
// Layer l has dilation 4^l, so it fires when the low 2*l bits of the
// per-sample phase counter are all zero.
package dilation_seq_pkg;

    // Default stack depth and the layer index width that goes with it
    localparam int NUM_LAYERS_DEFAULT = 4;
    localparam int LAYER_W            = $clog2(NUM_LAYERS_DEFAULT);

    // Widest phase counter supported (8 layers -> 2*(8-1) bits)
    localparam int MAX_CNT_W = 14;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        START,
        WAIT,
        DONE
    } seq_state_t;

    // Returns 1 when the given layer fires for the given phase count,
    // i.e. when the low 2*layer bits of the counter are all zero.
    function automatic logic fires(input logic [MAX_CNT_W-1:0] counter,
                                   input int                   layer);
        logic result;
        result = 1'b1;
        for (int i = 0; i < MAX_CNT_W; i++) begin
            if ((i < 2 * layer) && counter[i]) begin
                result = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dilation_phase_counter.sv
// Per-sample phase counter for the dilation sequencer. Counts completed
// samples modulo 2^CNT_W and publishes which layers fire for the sample
// currently being processed. Bit 0 of the mask is always set.
module dilation_phase_counter
    import dilation_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 2 * (NUM_LAYERS - 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [CNT_W-1:0]      cnt,
    output logic [NUM_LAYERS-1:0] fire_mask
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: advance by one per completed sample, wrapping silently
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fire mask: layer l fires when the low 2*l counter bits are zero
    always_comb begin
        fire_mask    = '0;
        fire_mask[0] = 1'b1;
        for (int l = 1; l < NUM_LAYERS; l++) begin
            fire_mask[l] = fires(MAX_CNT_W'(cnt_q), l);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dilation_layer_sequencer.sv
// Per-sample scheduler for a cached dilated causal convolution stack.
// For every accepted sample it walks the firing layers in order: shift the
// layer's 4-tap activation buffer, start the shared conv unit, wait for it,
// and feed its result into the next layer's buffer. The deepest result is
// published with a one-cycle out_valid pulse.
module dilation_layer_sequencer
    import dilation_seq_pkg::*;
#(
    parameter int W          = 16,
    parameter int NUM_LAYERS = 4,
    parameter int CNT_W      = 2 * (NUM_LAYERS - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [W-1:0]                  in_data,
    output logic                          in_ready,
    output logic [NUM_LAYERS-1:0]         shift_en,
    output logic [W-1:0]                  shift_data,
    output logic                          conv_start,
    output logic [$clog2(NUM_LAYERS)-1:0] conv_layer,
    input  logic                          conv_done,
    input  logic [W-1:0]                  conv_result,
    output logic                          out_valid,
    output logic [W-1:0]                  out_data,
    output logic [$clog2(NUM_LAYERS)-1:0] out_depth
);

    localparam int LW = $clog2(NUM_LAYERS);
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    seq_state_t state_q, state_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [W-1:0]  sample_q, sample_d;
    logic [W-1:0]  result_q, result_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [LW-1:0] out_depth_q, out_depth_d;

    logic [CNT_W-1:0]      phase_cnt;
    logic [NUM_LAYERS-1:0] fire_mask;
    logic                  next_fires;
    logic                  phase_inc;

    // The phase only advances once a sample has been fully sequenced
    assign phase_inc = (state_q == DONE);

    dilation_phase_counter #(
        .NUM_LAYERS (NUM_LAYERS),
        .CNT_W      (CNT_W)
    ) u_phase_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (phase_inc),
        .cnt       (phase_cnt),
        .fire_mask (fire_mask)
    );

    // Does the layer after the current one fire for this sample?
    always_comb begin
        next_fires = 1'b0;
        for (int l = 1; l < NUM_LAYERS; l++) begin
            if (int'(layer_q) + 1 == l) begin
                next_fires = fire_mask[l];
            end
        end
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            layer_q     <= '0;
            sample_q    <= '0;
            result_q    <= '0;
            out_data_q  <= '0;
            out_depth_q <= '0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            sample_q    <= sample_d;
            result_q    <= result_d;
            out_data_q  <= out_data_d;
            out_depth_q <= out_depth_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        sample_d    = sample_q;
        result_d    = result_q;
        out_data_d  = out_data_q;
        out_depth_d = out_depth_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sample_d = in_data;
                    layer_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                state_d = START;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    result_d = conv_result;
                    if ((layer_q != LAST_LAYER) && next_fires) begin
                        layer_d = layer_q + LW'(1);
                        state_d = SHIFT;
                    end else begin
                        // Publish now so the values are already valid while
                        // out_valid is high, and hold them until the next DONE
                        out_data_d  = conv_result;
                        out_depth_d = layer_q;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        in_ready   = 1'b0;
        shift_en   = '0;
        shift_data = '0;
        conv_start = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                shift_en   = NUM_LAYERS'(1) << layer_q;
                shift_data = (layer_q == '0) ? sample_q : result_q;
            end
            START: begin
                conv_start = 1'b1;
            end
            WAIT: begin
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // The layer index is only changed on SHIFT entry, so it is stable from
    // START through WAIT
    assign conv_layer = layer_q;
    assign out_data   = out_data_q;
    assign out_depth  = out_depth_q;

endmodule

// File: tb/tb_dilation_layer_sequencer.sv
// Self-checking bench for dilation_layer_sequencer (W=16, NUM_LAYERS=4).
// Table-driven sample vectors plus hand-written stall, stray-done, reset
// and counter-wrap sequences.
module tb_dilation_layer_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  shift_en;
    logic [15:0] shift_data;
    logic        conv_start;
    logic [1:0]  conv_layer;
    logic        conv_done;
    logic [15:0] conv_result;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_depth;

    int checkCount;
    int failCount;
    logic [15:0] expOutData;
    int          expOutDepth;
    int          phase;

    typedef struct {
        logic [15:0]      data;
        logic [3:0][15:0] res;
        int               expDepth;
    } sample_vec_t;

    sample_vec_t vecs[5];

    dilation_layer_sequencer #(
        .W          (16),
        .NUM_LAYERS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .shift_en    (shift_en),
        .shift_data  (shift_data),
        .conv_start  (conv_start),
        .conv_layer  (conv_layer),
        .conv_done   (conv_done),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_depth   (out_depth)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Number of layers beyond layer 0 that fire: trailing zero base-4 digits
    function automatic int expectedDepth(input int c);
        int d;
        int m;
        d = 0;
        m = 4;
        while (d < 3 && (c % m) == 0) begin
            d++;
            m = m * 4;
        end
        return d;
    endfunction

    function automatic logic [3:0][15:0] makeRes(input int c);
        logic [3:0][15:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l] = {8'(c), 8'(8'hA0 + l)};
        end
        return r;
    endfunction

    // Quiet checks while idle
    task automatic checkIdle(input string tag);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " shift_en"}, 32'(shift_en), 32'd0);
        checkOutput({tag, " conv_start"}, 32'(conv_start), 32'd0);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " out_data"}, 32'(out_data), 32'(expOutData));
        checkOutput({tag, " out_depth"}, 32'(out_depth), 32'(expOutDepth));
    endtask

    // Runs one sample from IDLE through DONE. Optional WAIT stall on layer 0
    // and optional reset abort in the WAIT of layer abortLayer (-1 = none).
    task automatic applyStimulus(input logic [15:0] data,
                                 input logic [3:0][15:0] res,
                                 input int expDepth,
                                 input int stallCycles,
                                 input int abortLayer);
        checkOutput("accept in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        step();
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        for (int l = 0; l <= expDepth; l++) begin
            checkOutput("shift in_ready", 32'(in_ready), 32'd0);
            checkOutput("shift_en", 32'(shift_en), 32'd1 << l);
            checkOutput("shift_data", 32'(shift_data),
                        32'((l == 0) ? data : res[(l == 0) ? 0 : l - 1]));
            checkOutput("shift conv_start", 32'(conv_start), 32'd0);
            step();
            checkOutput("conv_start", 32'(conv_start), 32'd1);
            checkOutput("conv_layer start", 32'(conv_layer), 32'(l));
            checkOutput("start shift_en", 32'(shift_en), 32'd0);
            step();
            checkOutput("wait conv_start", 32'(conv_start), 32'd0);
            checkOutput("conv_layer wait", 32'(conv_layer), 32'(l));
            if (abortLayer == l) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                expOutData  = 16'h0000;
                expOutDepth = 0;
                phase       = 0;
                checkIdle("abort");
                checkOutput("abort conv_layer", 32'(conv_layer), 32'd0);
                checkOutput("abort shift_data", 32'(shift_data), 32'd0);
                return;
            end
            if (l == 0) begin
                for (int s = 0; s < stallCycles; s++) begin
                    in_valid = s[0];
                    in_data  = 16'(16'h7000 + s);
                    step();
                    checkOutput("stall in_ready", 32'(in_ready), 32'd0);
                    checkOutput("stall out_valid", 32'(out_valid), 32'd0);
                    checkOutput("stall shift_en", 32'(shift_en), 32'd0);
                    checkOutput("stall conv_layer", 32'(conv_layer), 32'd0);
                    checkOutput("stall out_data", 32'(out_data), 32'(expOutData));
                end
                in_valid = 1'b0;
            end
            conv_done   = 1'b1;
            conv_result = res[l];
            step();
            conv_done   = 1'b0;
            conv_result = 16'hBEEF;
        end
        expOutData  = res[expDepth];
        expOutDepth = expDepth;
        checkOutput("done out_valid", 32'(out_valid), 32'd1);
        checkOutput("done out_data", 32'(out_data), 32'(expOutData));
        checkOutput("done out_depth", 32'(out_depth), 32'(expOutDepth));
        checkOutput("done in_ready", 32'(in_ready), 32'd0);
        step();
        checkIdle("post");
        phase = (phase + 1) % 64;
    endtask

    // Main test sequence
    initial begin
        checkCount  = 0;
        failCount   = 0;
        expOutData  = 16'h0000;
        expOutDepth = 0;
        phase       = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 16'h0000;
        conv_done   = 1'b0;
        conv_result = 16'h0000;

        vecs[0].data = 16'h0010;
        vecs[0].res[0] = 16'h1111; vecs[0].res[1] = 16'h2222;
        vecs[0].res[2] = 16'h3333; vecs[0].res[3] = 16'h4444;
        vecs[0].expDepth = 3;
        vecs[1].data = 16'h0020;
        vecs[1].res[0] = 16'h0A01; vecs[1].res[1] = 16'h0;
        vecs[1].res[2] = 16'h0;    vecs[1].res[3] = 16'h0;
        vecs[1].expDepth = 0;
        vecs[2].data = 16'h0030;
        vecs[2].res[0] = 16'h0B02; vecs[2].res[1] = 16'h0;
        vecs[2].res[2] = 16'h0;    vecs[2].res[3] = 16'h0;
        vecs[2].expDepth = 0;
        vecs[3].data = 16'h0040;
        vecs[3].res[0] = 16'h0C03; vecs[3].res[1] = 16'h0;
        vecs[3].res[2] = 16'h0;    vecs[3].res[3] = 16'h0;
        vecs[3].expDepth = 0;
        vecs[4].data = 16'h0050;
        vecs[4].res[0] = 16'h1234; vecs[4].res[1] = 16'h5678;
        vecs[4].res[2] = 16'h0;    vecs[4].res[3] = 16'h0;
        vecs[4].expDepth = 1;

        step();
        step();
        checkIdle("reset");
        checkOutput("reset shift_data", 32'(shift_data), 32'd0);
        checkOutput("reset conv_layer", 32'(conv_layer), 32'd0);
        rst = 1'b0;

        $display("[TB] table vectors, phase 0..4");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].res, vecs[i].expDepth, 0, -1);
        end

        $display("[TB] stall in WAIT with in_valid toggling");
        applyStimulus(16'h0060, makeRes(5), 0, 20, -1);

        $display("[TB] stray conv_done while idle");
        conv_done   = 1'b1;
        conv_result = 16'hFFFF;
        step();
        conv_done   = 1'b0;
        checkIdle("stray");

        $display("[TB] phases 6..15");
        while (phase != 16) begin
            applyStimulus(16'(16'h0100 + phase), makeRes(phase),
                          expectedDepth(phase), 0, -1);
        end

        $display("[TB] reset during WAIT of layer 2");
        applyStimulus(16'h0AAA, makeRes(16), 3, 0, 2);
        conv_done   = 1'b1;
        conv_result = 16'hCAFE;
        step();
        conv_done   = 1'b0;
        checkIdle("abort stray");
        applyStimulus(16'h0BBB, makeRes(40), 3, 0, -1);

        $display("[TB] 64-sample counter wrap");
        rst = 1'b1;
        step();
        rst = 1'b0;
        expOutData  = 16'h0000;
        expOutDepth = 0;
        phase       = 0;
        for (int n = 0; n < 64; n++) begin
            applyStimulus(16'(16'h2000 + n), makeRes(n), expectedDepth(n), 0, -1);
        end
        applyStimulus(16'h3000, makeRes(99), 3, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/dilation_layer_sequencer.md
Name: dilation_layer_sequencer

Overview:
Per-sample scheduler for the cached dilated causal convolution stack. On each accepted input sample it decides which layers fire, then sequences each firing layer in order. For each layer it first shifts that layer's 4-tap left-shift activation buffer, then starts the shared convolution unit and waits for it to finish. It sits between the audio/sample front end and the per-layer 4-tap buffers plus the single time-shared conv MAC unit.

Parameters:
W, 16, element width of samples and activations
NUM_LAYERS, 4, number of conv layers; layer l has dilation 4^l; legal range 2..8
CNT_W, 2*(NUM_LAYERS-1), derived width of the sample phase counter; not overridden

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  new input sample offered
in_data  input  W  input sample
in_ready  output  1  sequencer can accept a sample
shift_en  output  NUM_LAYERS  one-hot shift strobe to the layer-l 4-tap buffer
shift_data  output  W  value to shift into the strobed buffer
conv_start  output  1  one-cycle start pulse to the shared conv unit
conv_layer  output  $clog2(NUM_LAYERS)  layer index the conv unit must use; held stable from START through WAIT
conv_done  input  1  conv unit finished (single-cycle pulse)
conv_result  input  W  conv unit output, valid when conv_done=1
out_valid  output  1  one-cycle pulse: sample processing complete
out_data  output  W  result of the deepest layer fired this sample
out_depth  output  $clog2(NUM_LAYERS)  index of the deepest layer fired this sample

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The ports are named clk and rst.
- Reset values:
  - state=IDLE, phase counter=0, layer=0.
  - in_ready=1.
  - shift_en=0, conv_start=0, out_valid=0.
  - shift_data, out_data, out_depth, conv_layer all 0.
- Fire rule: layer l fires for a sample iff the low 2*l bits of the phase counter are zero.
  - Layer 0 always fires.
  - At counter=0 all layers fire.
  - The fired set is always contiguous from layer 0, so sequencing stops at the first non-firing layer.
- FSM states are IDLE, SHIFT, START, WAIT, DONE.
  - IDLE: in_ready=1. If in_valid, latch in_data, set layer=0, go to SHIFT. in_ready is 0 in every other state.
  - SHIFT (1 cycle): shift_en[layer]=1. shift_data = latched in_data for layer 0, otherwise the registered conv_result of layer-1. Next state START.
  - START (1 cycle): conv_start=1, conv_layer=layer. Next state WAIT.
  - WAIT: hold until conv_done.
    - On conv_done, register conv_result.
    - If layer<NUM_LAYERS-1 and layer+1 fires: layer++ and go to SHIFT.
    - Otherwise go to DONE.
  - DONE (1 cycle):
    - out_valid=1, out_data=registered result, out_depth=layer.
    - Phase counter increments modulo 2^CNT_W; wrap to 0 is silent.
    - Next state IDLE.
- Timing:
  - Accept at cycle T.
  - shift_en at T+1, conv_start at T+2.
  - Minimum single-layer latency (conv_done in the cycle after START) is out_valid at T+4.
  - in_ready returns at T+5.
- out_data and out_depth hold their values until the next DONE.
- Boundary conditions:
  - conv_done outside WAIT is ignored.
  - conv_done in the same cycle as conv_start is impossible, because START precedes WAIT.
  - in_valid while in_ready=0 is ignored (no buffering, sample not consumed).
  - rst asserted in any state returns everything to the reset values on the next edge. Any in-flight conv is abandoned, and a later stray conv_done is ignored because state is IDLE.
  - NUM_LAYERS=2 gives CNT_W=2; layer 1 fires every 4th sample.

Decomposition:
- Package dilation_seq_pkg holds:
  - state enum seq_state_t {IDLE, SHIFT, START, WAIT, DONE}
  - function fires(counter, layer) returning a 1-bit result
  - localparam LAYER_W = $clog2(NUM_LAYERS) as a helper
- Sub-module dilation_phase_counter:
  - holds the CNT_W-bit counter with an increment strobe
  - exports a NUM_LAYERS-bit fire mask, bit l = ~|cnt[2l-1:0]
  - bit 0 is tied to 1

Test Plan:
- Reset, then sample 0x0010 with conv_done 1 cycle after each start (counter=0), NUM_LAYERS=4 -> shift_en sequence 0001,0010,0100,1000; conv_layer 0..3; out_valid with out_depth=3; out_data = 4th conv_result.
- Second sample 0x0020 (counter=1) -> only layer 0 fires; shift_data=0x0020; out_depth=0; out_valid at accept+4.
- Samples 2..4 -> counter=4 fires layers 0,1 only (out_depth=1); layer-1 shift_data equals layer-0 conv_result (drive 0x1234 -> observe 0x1234).
- Stall conv_done for 20 cycles in WAIT, toggle in_valid meanwhile -> in_ready=0, no sample consumed, outputs held; conv_done arriving while IDLE -> no state change.
- Assert rst during WAIT at layer 2 -> next cycle IDLE, in_ready=1, counter=0; following sample fires all 4 layers again.
- Drive 64 samples (CNT_W=6) -> counter wraps; the 65th sample fires all layers, out_depth=3.
